// File: rtl/bp_io_cmd_tracker_pkg.sv
// Memory-interface message layout and the I/O tracker entry shared by the tracker and its bench.
// Widths here stand in for the processor configuration of the default build.
package bp_io_cmd_tracker_pkg;

    localparam int unsigned paddr_width_p     = 40;
    localparam int unsigned cce_block_width_p = 64;
    localparam int unsigned lce_id_width_p    = 4;
    localparam int unsigned lce_assoc_p       = 8;
    localparam int unsigned lce_way_width_lp  = $clog2(lce_assoc_p);

    typedef enum logic [3:0] {
        MemRd   = 4'd0,
        MemWr   = 4'd1,
        MemUcRd = 4'd2,
        MemUcWr = 4'd3
    } bp_mem_msg_type_e;

    typedef enum logic [2:0] {
        Size1  = 3'd0,
        Size2  = 3'd1,
        Size4  = 3'd2,
        Size8  = 3'd3,
        Size16 = 3'd4,
        Size32 = 3'd5,
        Size64 = 3'd6
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [2:0]                  state;
        logic [lce_way_width_lp-1:0] way_id;
        logic [lce_id_width_p-1:0]   lce_id;
    } bp_mem_msg_payload_s;

    typedef struct packed {
        bp_mem_msg_payload_s      payload;
        bp_mem_msg_size_e         size;
        logic [paddr_width_p-1:0] addr;
        bp_mem_msg_type_e         msg_type;
    } bp_mem_msg_header_s;

    typedef struct packed {
        bp_mem_msg_header_s           header;
        logic [cce_block_width_p-1:0] data;
    } bp_mem_msg_s;

    // One in-flight command as remembered by the tracker.
    typedef struct packed {
        bp_mem_msg_payload_s      payload;
        bp_mem_msg_size_e         size;
        logic [paddr_width_p-1:0] addr;
        bp_mem_msg_type_e         msg_type;
    } bp_io_trk_entry_s;

    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_mem_msg_s);

endpackage

// File: rtl/bp_io_cmd_tracker_fifo.sv
// Small in-order circular buffer: one write and one read per cycle, pointers wrap modulo depth.
// ready_o and v_o are pure functions of the registered count.
module bp_io_cmd_tracker_fifo #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]      mem_q [els_p];

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
        if (ptr == ptr_width_lp'(els_p - 1)) begin
            return '0;
        end
        return ptr + ptr_width_lp'(1);
    endfunction

    assign ready_o = (cnt_q != cnt_width_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (v_i) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (yumi_i) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({v_i, yumi_i})
            2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_io_cmd_tracker.sv
// Bounds outstanding I/O commands and restores payload/size/addr onto the zero-payload responses
// coming back from the link converter; flags orphan responses and address mismatches.
module bp_io_cmd_tracker
    import bp_io_cmd_tracker_pkg::*;
#(
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,

    output logic                            error_o
);

    bp_mem_msg_s      cmd_msg, resp_in, resp_d, resp_q;
    bp_io_trk_entry_s trk_in, trk_head;
    logic             trk_ready, trk_v, trk_full, trk_empty;
    logic             resp_accept, trk_pop, orphan, addr_mismatch;
    logic             resp_v_q, resp_v_d, error_q, error_d;

    assign cmd_msg = bp_mem_msg_s'(io_cmd_i);
    assign resp_in = bp_mem_msg_s'(io_resp_i);

    // Command path is a wire; only the valid is gated by the registered fullness.
    assign io_cmd_o      = io_cmd_i;
    assign io_cmd_v_o    = io_cmd_v_i & ~trk_full;
    assign io_cmd_yumi_o = io_cmd_yumi_i;

    always_comb begin
        trk_in          = '0;
        trk_in.payload  = cmd_msg.header.payload;
        trk_in.size     = cmd_msg.header.size;
        trk_in.addr     = cmd_msg.header.addr;
        trk_in.msg_type = cmd_msg.header.msg_type;
    end

    bp_io_cmd_tracker_fifo #(
        .els_p   (max_outstanding_p),
        .width_p ($bits(bp_io_trk_entry_s))
    ) u_trk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (trk_in),
        .v_i     (io_cmd_yumi_i),
        .ready_o (trk_ready),
        .data_o  (trk_head),
        .v_o     (trk_v),
        .yumi_i  (trk_pop)
    );

    assign trk_full  = ~trk_ready;
    assign trk_empty = ~trk_v;

    assign io_resp_ready_o = ~resp_v_q | io_resp_yumi_i;
    assign resp_accept     = io_resp_v_i & io_resp_ready_o;
    assign trk_pop         = resp_accept & ~trk_empty;
    assign orphan          = resp_accept & trk_empty;
    assign addr_mismatch   = trk_pop & (trk_head.addr != resp_in.header.addr);

    always_comb begin
        resp_d                = resp_in;
        resp_d.header.payload = trk_head.payload;
        resp_d.header.size    = trk_head.size;
        resp_d.header.addr    = trk_head.addr;

        resp_v_d = resp_v_q;
        if (trk_pop) begin
            resp_v_d = 1'b1;
        end else if (io_resp_yumi_i) begin
            resp_v_d = 1'b0;
        end

        error_d = error_q | orphan | addr_mismatch;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            resp_v_q <= resp_v_d;
            error_q  <= error_d;
        end
    end

    // Loads only on a pop, which already implies the slot is free or draining this cycle.
    always_ff @(posedge clk_i) begin
        if (trk_pop) begin
            resp_q <= resp_d;
        end
    end

    assign io_resp_o   = resp_q;
    assign io_resp_v_o = resp_v_q;
    assign error_o     = error_q;

    logic unused_fields;
    assign unused_fields = ^{cmd_msg.data, trk_head.msg_type};

endmodule

// File: tb/tb_bp_io_cmd_tracker.sv
// Scoreboard bench for bp_io_cmd_tracker: the bench plays network and converter, queues the
// restored response it expects whenever it offers one, and compares when the DUT presents it.
module tb_bp_io_cmd_tracker;
    import bp_io_cmd_tracker_pkg::*;

    localparam int unsigned W = cce_mem_msg_width_lp;

    logic         clk = 1'b0;
    logic         reset;
    bp_mem_msg_s  cmd_msg, resp_msg, resp_out;
    logic         cmd_v, cmd_yumi, resp_v, resp_yumi;
    logic [W-1:0] io_cmd_o, io_resp_o;
    logic         io_cmd_yumi_o, io_cmd_v_o, io_resp_ready_o, io_resp_v_o, error_o;

    int n_cmp = 0;
    int n_err = 0;

    bp_mem_msg_s cmd_q[$];
    bp_mem_msg_s exp_q[$];

    bp_io_cmd_tracker #(
        .max_outstanding_p (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .io_cmd_i        (cmd_msg),
        .io_cmd_v_i      (cmd_v),
        .io_cmd_yumi_o   (io_cmd_yumi_o),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_yumi_i   (cmd_yumi),
        .io_resp_i       (resp_msg),
        .io_resp_v_i     (resp_v),
        .io_resp_ready_o (io_resp_ready_o),
        .io_resp_o       (io_resp_o),
        .io_resp_v_o     (io_resp_v_o),
        .io_resp_yumi_i  (resp_yumi),
        .error_o         (error_o)
    );

    assign resp_out = bp_mem_msg_s'(io_resp_o);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bp_mem_msg_s make_cmd(input logic [paddr_width_p-1:0] addr,
                                             input logic [lce_id_width_p-1:0] lce);
        bp_mem_msg_s m;
        m                        = '0;
        m.header.msg_type        = MemUcRd;
        m.header.addr            = addr;
        m.header.size            = Size8;
        m.header.payload.lce_id  = lce;
        m.header.payload.way_id  = lce[2:0];
        m.header.payload.state   = 3'd5;
        m.data                   = {$urandom, $urandom};
        return m;
    endfunction

    // Converter-style response: header payload and size zeroed, fresh data.
    function automatic bp_mem_msg_s make_resp(input bp_mem_msg_s cmd);
        bp_mem_msg_s r;
        r                 = '0;
        r.header.msg_type = cmd.header.msg_type;
        r.header.addr     = cmd.header.addr;
        r.data            = {$urandom, $urandom};
        return r;
    endfunction

    function automatic bp_mem_msg_s restore(input bp_mem_msg_s r, input bp_mem_msg_s cmd);
        bp_mem_msg_s e;
        e                = r;
        e.header.payload = cmd.header.payload;
        e.header.size    = cmd.header.size;
        e.header.addr    = cmd.header.addr;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_v     = 1'b0;
        cmd_yumi  = 1'b0;
        resp_v    = 1'b0;
        resp_yumi = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmd_q.delete();
        exp_q.delete();
    endtask

    task automatic send_cmd(input bp_mem_msg_s m, output logic accepted);
        @(negedge clk);
        cmd_msg = m;
        cmd_v   = 1'b1;
        #1;
        accepted = io_cmd_v_o;
        cmd_yumi = accepted;
        @(posedge clk);
        #1;
        if (accepted) cmd_q.push_back(m);
        cmd_v    = 1'b0;
        cmd_yumi = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b1;
        cmd_msg = make_cmd(40'h10, 4'd1);
        cmd_v   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (io_resp_v_o !== 1'b0) begin
            n_err++; $display("FAIL reset_resp_v: got %b want 0", io_resp_v_o);
        end
        n_cmp++; if (io_resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", io_resp_ready_o);
        end
        n_cmp++; if (error_o !== 1'b0) begin
            n_err++; $display("FAIL reset_error: got %b want 0", error_o);
        end
        n_cmp++; if (io_cmd_v_o !== 1'b1) begin
            n_err++; $display("FAIL reset_cmd_v: got %b want 1", io_cmd_v_o);
        end
        reset = 1'b0;
        cmd_v = 1'b0;
    endtask

    task automatic test_single_read();
        bp_mem_msg_s c, r, e;
        do_reset();
        c = make_cmd(40'h8000_1000, 4'd3);
        @(negedge clk);
        cmd_msg = c;
        cmd_v   = 1'b1;
        #1;
        n_cmp++; if (io_cmd_v_o !== 1'b1) begin
            n_err++; $display("FAIL single_cmd_v: got %b want 1", io_cmd_v_o);
        end
        n_cmp++; if (io_cmd_o !== W'(c)) begin
            n_err++; $display("FAIL single_cmd_pass: got %h want %h", io_cmd_o, c);
        end
        cmd_yumi = 1'b1;
        #1;
        n_cmp++; if (io_cmd_yumi_o !== 1'b1) begin
            n_err++; $display("FAIL single_cmd_yumi: got %b want 1", io_cmd_yumi_o);
        end
        @(posedge clk);
        #1;
        cmd_v    = 1'b0;
        cmd_yumi = 1'b0;
        r = make_resp(c);
        exp_q.push_back(restore(r, c));
        @(negedge clk);
        resp_msg = r;
        resp_v   = 1'b1;
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b1) begin
            n_err++; $display("FAIL single_resp_v: got %b want 1", io_resp_v_o);
        end
        e = exp_q.pop_front();
        n_cmp++; if (resp_out !== e) begin
            n_err++; $display("FAIL single_resp: got %h want %h", resp_out, e);
        end
        n_cmp++; if (resp_out.header.payload.lce_id !== 4'd3) begin
            n_err++; $display("FAIL single_lce: got %0d want 3", resp_out.header.payload.lce_id);
        end
        n_cmp++; if (error_o !== 1'b0) begin
            n_err++; $display("FAIL single_error: got %b want 0", error_o);
        end
        @(negedge clk);
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got %b want 0", io_resp_v_o);
        end
    endtask

    task automatic test_fill();
        bp_mem_msg_s c5, r, e;
        logic acc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_cmd(make_cmd(40'h1000 + 40'(i * 64), 4'(i)), acc);
            n_cmp++; if (acc !== 1'b1) begin
                n_err++; $display("FAIL fill_accept%0d: got %b want 1", i, acc);
            end
        end
        c5 = make_cmd(40'h2000, 4'd9);
        @(negedge clk);
        cmd_msg = c5;
        cmd_v   = 1'b1;
        #1;
        n_cmp++; if (io_cmd_v_o !== 1'b0) begin
            n_err++; $display("FAIL fill_full: got %b want 0", io_cmd_v_o);
        end
        r = make_resp(cmd_q[0]);
        exp_q.push_back(restore(r, cmd_q.pop_front()));
        resp_msg = r;
        resp_v   = 1'b1;
        #1;
        n_cmp++; if (io_cmd_v_o !== 1'b0) begin
            n_err++; $display("FAIL fill_same_cycle: got %b want 0", io_cmd_v_o);
        end
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        n_cmp++; if (io_cmd_v_o !== 1'b1) begin
            n_err++; $display("FAIL fill_next_cycle: got %b want 1", io_cmd_v_o);
        end
        e = exp_q.pop_front();
        n_cmp++; if (io_resp_v_o !== 1'b1 || resp_out !== e) begin
            n_err++; $display("FAIL fill_resp: got v=%b %h want v=1 %h", io_resp_v_o, resp_out, e);
        end
        cmd_yumi = 1'b1;
        @(posedge clk);
        #1;
        cmd_yumi = 1'b0;
        cmd_q.push_back(c5);
        n_cmp++; if (io_cmd_v_o !== 1'b0) begin
            n_err++; $display("FAIL fill_refull: got %b want 0", io_cmd_v_o);
        end
        cmd_v = 1'b0;
    endtask

    task automatic test_back_to_back();
        bp_mem_msg_s r, e;
        logic acc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_cmd(make_cmd(40'h3000 + 40'(i * 64), 4'(i + 1)), acc);
        end
        resp_yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                r = make_resp(cmd_q[0]);
                exp_q.push_back(restore(r, cmd_q.pop_front()));
                resp_msg = r;
                resp_v   = 1'b1;
            end else begin
                resp_v = 1'b0;
            end
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (io_resp_v_o !== 1'b1 || resp_out !== e) begin
                    n_err++;
                    $display("FAIL b2b_resp%0d: got v=%b %h want v=1 %h",
                             i - 1, io_resp_v_o, resp_out, e);
                end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (io_resp_v_o !== 1'b0 || error_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got v=%b err=%b want 0 0", io_resp_v_o, error_o);
        end
        resp_yumi = 1'b0;
    endtask

    task automatic test_backpressure();
        bp_mem_msg_s ra, rb, ea, e;
        logic acc;
        do_reset();
        send_cmd(make_cmd(40'h4000, 4'd6), acc);
        send_cmd(make_cmd(40'h4040, 4'd7), acc);
        @(negedge clk);
        ra = make_resp(cmd_q[0]);
        exp_q.push_back(restore(ra, cmd_q.pop_front()));
        resp_msg = ra;
        resp_v   = 1'b1;
        @(posedge clk);
        #1;
        rb       = make_resp(cmd_q[0]);
        resp_msg = rb;
        ea       = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (io_resp_v_o !== 1'b1 || resp_out !== ea || io_resp_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b %h want v=1 rdy=0 %h",
                         k, io_resp_v_o, io_resp_ready_o, resp_out, ea);
            end
        end
        @(negedge clk);
        resp_yumi = 1'b1;
        #1;
        n_cmp++; if (io_resp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 1", io_resp_ready_o);
        end
        exp_q.push_back(restore(rb, cmd_q.pop_front()));
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        n_cmp++; if (io_resp_v_o !== 1'b1 || resp_out !== e) begin
            n_err++; $display("FAIL bp_second: got v=%b %h want v=1 %h", io_resp_v_o, resp_out, e);
        end
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b0 || error_o !== 1'b0) begin
            n_err++; $display("FAIL bp_end: got v=%b err=%b want 0 0", io_resp_v_o, error_o);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        @(negedge clk);
        resp_msg = make_resp(make_cmd(40'h5000, 4'd1));
        resp_v   = 1'b1;
        #1;
        n_cmp++; if (io_resp_ready_o !== 1'b1 || error_o !== 1'b0) begin
            n_err++;
            $display("FAIL orphan_pre: got rdy=%b err=%b want 1 0", io_resp_ready_o, error_o);
        end
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b0 || error_o !== 1'b1) begin
            n_err++; $display("FAIL orphan: got v=%b err=%b want 0 1", io_resp_v_o, error_o);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (error_o !== 1'b1) begin
            n_err++; $display("FAIL orphan_sticky: got %b want 1", error_o);
        end
    endtask

    task automatic test_addr_mismatch();
        bp_mem_msg_s r, e;
        logic acc;
        do_reset();
        send_cmd(make_cmd(40'h1000, 4'd5), acc);
        r             = make_resp(cmd_q[0]);
        r.header.addr = 40'h2000;
        exp_q.push_back(restore(r, cmd_q.pop_front()));
        n_cmp++; if (error_o !== 1'b0) begin
            n_err++; $display("FAIL mismatch_pre: got %b want 0", error_o);
        end
        @(negedge clk);
        resp_msg = r;
        resp_v   = 1'b1;
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (io_resp_v_o !== 1'b1 || resp_out !== e) begin
            n_err++;
            $display("FAIL mismatch_resp: got v=%b %h want v=1 %h", io_resp_v_o, resp_out, e);
        end
        n_cmp++; if (resp_out.header.addr !== 40'h1000 || error_o !== 1'b1) begin
            n_err++;
            $display("FAIL mismatch_flag: got addr=%h err=%b want 1000 1",
                     resp_out.header.addr, error_o);
        end
        @(negedge clk);
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bp_mem_msg_s late;
        logic acc;
        do_reset();
        send_cmd(make_cmd(40'h6000, 4'd2), acc);
        send_cmd(make_cmd(40'h6040, 4'd4), acc);
        @(negedge clk);
        resp_msg = make_resp(cmd_q.pop_front());
        resp_v   = 1'b1;
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: got %b want 1", io_resp_v_o);
        end
        late = make_resp(cmd_q.pop_front());
        @(negedge clk);
        reset   = 1'b1;
        cmd_msg = make_cmd(40'h7000, 4'd8);
        cmd_v   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (io_resp_v_o !== 1'b0 || io_resp_ready_o !== 1'b1 || error_o !== 1'b0 ||
            io_cmd_v_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b rdy=%b err=%b cmdv=%b want 0 1 0 1",
                     io_resp_v_o, io_resp_ready_o, error_o, io_cmd_v_o);
        end
        cmd_v    = 1'b0;
        resp_msg = late;
        resp_v   = 1'b1;
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        n_cmp++; if (io_resp_v_o !== 1'b0 || error_o !== 1'b1) begin
            n_err++; $display("FAIL mid_orphan: got v=%b err=%b want 0 1", io_resp_v_o, error_o);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_msg   = '0;
        resp_msg  = '0;
        cmd_v     = 1'b0;
        cmd_yumi  = 1'b0;
        resp_v    = 1'b0;
        resp_yumi = 1'b0;

        test_reset();
        test_single_read();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_orphan();
        test_addr_mismatch();
        test_reset_midflight();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
